// File: rtl/stats_accumulator_pkg.sv
// Shared definitions for the statistics accumulator: FSM encoding and register-map word helpers.
// No logic and no latency of its own.
// No flow control here; the helpers are also used by the register map generator.
package stats_accumulator_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_UPD_RD,
        ST_UPD_WR,
        ST_REG_RD,
        ST_REG_RSP
    } stat_state_t;

    // Number of register words that make up one counter
    function automatic int stat_words(input int count_width, input int reg_width);
        return count_width / reg_width;
    endfunction

    // Word-select field width, held at 1 bit minimum so it can always be declared
    function automatic int stat_word_sel_width(input int count_width, input int reg_width);
        int words;
        words = count_width / reg_width;
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/stats_ram_sp.sv
// Single-port counter RAM with registered read, kept separate so block RAM is inferred cleanly.
// Latency: read data valid one cycle after an enabled read.
// Backpressure: none; one access per cycle, a write does not update the read register.
module stats_ram_sp #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/stats_accumulator.sv
// Accumulates stream increments into wide per-counter RAM totals and serves them as register words.
// Latency: update is a 3-cycle read-modify-write; register read acks 3 cycles after en when idle.
// Backpressure: tready only in IDLE on a stat grant; register requests wait under round-robin.
module stats_accumulator
    import stats_accumulator_pkg::*;
#(
    parameter int STAT_INC_WIDTH   = 16,
    parameter int STAT_ID_WIDTH    = 5,
    parameter int STAT_COUNT_WIDTH = 64,
    parameter int REG_ADDR_WIDTH   = STAT_ID_WIDTH + $clog2(STAT_COUNT_WIDTH / 8),
    parameter int REG_DATA_WIDTH   = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [STAT_INC_WIDTH-1:0] s_axis_stat_tdata,
    input  logic [STAT_ID_WIDTH-1:0]  s_axis_stat_tid,
    input  logic                      s_axis_stat_tvalid,
    output logic                      s_axis_stat_tready,
    input  logic [REG_ADDR_WIDTH-1:0] reg_rd_addr,
    input  logic                      reg_rd_en,
    output logic [REG_DATA_WIDTH-1:0] reg_rd_data,
    output logic                      reg_rd_wait,
    output logic                      reg_rd_ack
);

    localparam int WORDS      = stat_words(STAT_COUNT_WIDTH, REG_DATA_WIDTH);
    localparam int SEL_W      = stat_word_sel_width(STAT_COUNT_WIDTH, REG_DATA_WIDTH);
    localparam int LOG_WORDS  = $clog2(WORDS);
    localparam int WORD_SHIFT = $clog2(REG_DATA_WIDTH / 8);

    stat_state_t state, state_nxt;

    logic [STAT_ID_WIDTH-1:0]              init_ptr;
    logic [STAT_ID_WIDTH-1:0]              upd_id;
    logic [STAT_INC_WIDTH-1:0]             upd_inc;
    logic [STAT_COUNT_WIDTH-1:0]           upd_cnt;
    logic                                  rd_pend;
    logic [REG_ADDR_WIDTH-1:0]             rd_addr_q;
    logic [WORDS-1:0][REG_DATA_WIDTH-1:0]  snapshot;
    logic [WORDS-1:0][REG_DATA_WIDTH-1:0]  ram_words;
    logic                                  last_reg;

    logic                                  grant_reg;
    logic                                  rd_accept;
    logic                                  upd_accept;
    logic [REG_ADDR_WIDTH-1:0]             word_idx;
    logic [STAT_ID_WIDTH-1:0]              rd_cnt_idx;
    logic [SEL_W-1:0]                      rd_word_sel;
    logic                                  addr_unused;

    logic                                  ram_en;
    logic                                  ram_we;
    logic [STAT_ID_WIDTH-1:0]              ram_addr;
    logic [STAT_COUNT_WIDTH-1:0]           ram_wdata;
    logic [STAT_COUNT_WIDTH-1:0]           ram_rdata;

    // Address bits above the counter index are dropped, so the address wraps into the table
    assign word_idx    = rd_addr_q >> WORD_SHIFT;
    assign rd_cnt_idx  = word_idx[LOG_WORDS +: STAT_ID_WIDTH];
    assign rd_word_sel = (WORDS > 1) ? word_idx[SEL_W-1:0] : '0;
    assign addr_unused = ^word_idx;

    assign ram_words   = ram_rdata;
    assign reg_rd_wait = rd_pend;

    // Register side wins unless it won last time and a beat is waiting
    assign grant_reg  = rd_pend && !(last_reg && s_axis_stat_tvalid);
    assign upd_accept = (state == ST_IDLE) && !grant_reg && s_axis_stat_tvalid;
    assign rd_accept  = reg_rd_en && !rd_pend && (state != ST_REG_RSP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:    if (init_ptr == '1) state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (grant_reg) begin
                    state_nxt = ST_REG_RD;
                end else if (s_axis_stat_tvalid) begin
                    state_nxt = ST_UPD_RD;
                end
            end
            ST_UPD_RD:  state_nxt = ST_UPD_WR;
            ST_UPD_WR:  state_nxt = ST_IDLE;
            ST_REG_RD:  state_nxt = ST_REG_RSP;
            ST_REG_RSP: state_nxt = ST_IDLE;
            default:    state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        s_axis_stat_tready = 1'b0;
        reg_rd_ack         = 1'b0;
        ram_en             = 1'b0;
        ram_we             = 1'b0;
        ram_addr           = upd_id;
        ram_wdata          = upd_cnt + STAT_COUNT_WIDTH'(upd_inc);
        case (state)
            ST_INIT: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = init_ptr;
                ram_wdata = '0;
            end
            ST_IDLE: begin
                s_axis_stat_tready = !grant_reg;
                if (grant_reg) begin
                    ram_en   = 1'b1;
                    ram_addr = rd_cnt_idx;
                end else if (s_axis_stat_tvalid) begin
                    ram_en   = 1'b1;
                    ram_addr = s_axis_stat_tid;
                end
            end
            ST_UPD_WR: begin
                ram_en = 1'b1;
                ram_we = 1'b1;
            end
            ST_REG_RSP: reg_rd_ack = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_ptr    <= '0;
            upd_id      <= '0;
            upd_inc     <= '0;
            upd_cnt     <= '0;
            rd_pend     <= 1'b0;
            rd_addr_q   <= '0;
            snapshot    <= '0;
            reg_rd_data <= '0;
            last_reg    <= 1'b0;
        end else begin
            if (state == ST_INIT) begin
                init_ptr <= init_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_pend   <= 1'b1;
                rd_addr_q <= reg_rd_addr;
            end
            if (upd_accept) begin
                upd_id  <= s_axis_stat_tid;
                upd_inc <= s_axis_stat_tdata;
            end
            if (state == ST_IDLE) begin
                if (grant_reg) begin
                    last_reg <= 1'b1;
                end else if (s_axis_stat_tvalid) begin
                    last_reg <= 1'b0;
                end
            end
            if (state == ST_UPD_RD) begin
                upd_cnt <= ram_rdata;
            end
            // Word 0 refreshes the snapshot; higher words come only from the snapshot
            if (state == ST_REG_RD) begin
                rd_pend <= 1'b0;
                if (rd_word_sel == '0) begin
                    snapshot    <= ram_words;
                    reg_rd_data <= ram_words[0];
                end else begin
                    reg_rd_data <= snapshot[rd_word_sel];
                end
            end
        end
    end

    stats_ram_sp #(
        .ADDR_WIDTH (STAT_ID_WIDTH),
        .DATA_WIDTH (STAT_COUNT_WIDTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_stats_accumulator.sv
// Directed bench for stats_accumulator: init, accumulation, wrap, snapshot coherence,
// arbitration under load and reset in the middle of transactions.
module tb_stats_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] s_axis_stat_tdata;
    logic [4:0]  s_axis_stat_tid;
    logic        s_axis_stat_tvalid;
    logic        s_axis_stat_tready;
    logic [7:0]  reg_rd_addr;
    logic        reg_rd_en;
    logic [31:0] reg_rd_data;
    logic        reg_rd_wait;
    logic        reg_rd_ack;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    stats_accumulator dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .s_axis_stat_tdata  (s_axis_stat_tdata),
        .s_axis_stat_tid    (s_axis_stat_tid),
        .s_axis_stat_tvalid (s_axis_stat_tvalid),
        .s_axis_stat_tready (s_axis_stat_tready),
        .reg_rd_addr        (reg_rd_addr),
        .reg_rd_en          (reg_rd_en),
        .reg_rd_data        (reg_rd_data),
        .reg_rd_wait        (reg_rd_wait),
        .reg_rd_ack         (reg_rd_ack)
    );

    // Issue one read of (counter, word) and wait for its ack; lat is cycles from en to ack
    task automatic reg_read(input int cnt, input int word, output logic [31:0] data, output int lat);
        @(negedge clk);
        reg_rd_addr = 8'(cnt * 8 + word * 4);
        reg_rd_en   = 1'b1;
        lat  = 0;
        data = '0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            reg_rd_en = 1'b0;
            #1;
            if (reg_rd_ack) begin
                lat  = i;
                data = reg_rd_data;
                break;
            end
        end
        if (lat == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL read_timeout: counter %0d word %0d got no ack in 100 cycles, required an ack", cnt, word);
        end
    endtask

    task automatic send_beat(input int id, input int inc);
        int seen;
        seen = 0;
        @(negedge clk);
        s_axis_stat_tvalid = 1'b1;
        s_axis_stat_tid    = 5'(id);
        s_axis_stat_tdata  = 16'(inc);
        for (int i = 0; i < 100; i++) begin
            #1;
            if (s_axis_stat_tready) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (seen == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL beat_timeout: id %0d tready never high in 100 cycles, required a handshake", id);
        end
        @(negedge clk);
        s_axis_stat_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        int          hi_cnt;
        int          wait_bad;
        int          got;
        int          lat;
        logic [31:0] d;
        rst_n              = 1'b0;
        s_axis_stat_tvalid = 1'b1;
        s_axis_stat_tid    = 5'd0;
        s_axis_stat_tdata  = 16'd0;
        reg_rd_en          = 1'b0;
        reg_rd_addr        = 8'd0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (s_axis_stat_tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready: got %b required 0", s_axis_stat_tready); end
        n_cmp++; if (reg_rd_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b required 0", reg_rd_ack); end
        n_cmp++; if (reg_rd_wait !== 1'b0) begin n_fail++; $display("FAIL rst_wait: got %b required 0", reg_rd_wait); end
        n_cmp++; if (reg_rd_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h required 0", reg_rd_data); end

        // Release with a beat waiting; post a register read during INIT
        @(negedge clk);
        rst_n    = 1'b1;
        hi_cnt   = 0;
        wait_bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (i == 4) begin
                reg_rd_addr = 8'(4 * 8);
                reg_rd_en   = 1'b1;
            end
            if (i == 5) reg_rd_en = 1'b0;
            #1;
            if (s_axis_stat_tready) hi_cnt++;
            if (i >= 5 && (!reg_rd_wait || reg_rd_ack)) wait_bad++;
            @(negedge clk);
        end
        n_cmp++; if (hi_cnt !== 0) begin n_fail++; $display("FAIL init_tready: high %0d cycles during INIT, required 0", hi_cnt); end
        n_cmp++; if (wait_bad !== 0) begin n_fail++; $display("FAIL init_wait: %0d cycles without wait, required 0", wait_bad); end

        got = 0;
        d   = 32'hDEAD_BEEF;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (reg_rd_ack) begin
                got = 1;
                d   = reg_rd_data;
                break;
            end
            @(negedge clk);
        end
        n_cmp++; if (got !== 1) begin n_fail++; $display("FAIL init_read_ack: got %0d required 1", got); end
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL init_read_data: got %h required 0", d); end

        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (s_axis_stat_tready) begin
                got = 1;
                break;
            end
        end
        n_cmp++; if (got !== 1) begin n_fail++; $display("FAIL post_init_tready: got %0d required 1", got); end
        @(negedge clk);
        s_axis_stat_tvalid = 1'b0;

        for (int c = 0; c < 32; c++) begin
            reg_read(c, 0, d, lat);
            n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL zero_cnt%0d: got %h required 0", c, d); end
        end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        int          lat;
        send_beat(3, 16'h0010);
        send_beat(3, 16'hFFFF);
        send_beat(7, 16'h0001);
        repeat (4) @(negedge clk);
        reg_read(3, 0, d, lat);
        n_cmp++; if (d !== 32'h0001_000F) begin n_fail++; $display("FAIL cnt3_w0: got %h required 0001000f", d); end
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL idle_latency: got %0d required 3", lat); end
        reg_read(3, 1, d, lat);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL cnt3_w1: got %h required 0", d); end
        reg_read(7, 0, d, lat);
        n_cmp++; if (d !== 32'h1) begin n_fail++; $display("FAIL cnt7_w0: got %h required 1", d); end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        int          lat;
        @(negedge clk);
        dut.u_ram.mem[5] <= 64'hFFFF_FFFF_FFFF_FFF0;
        send_beat(5, 16'h0020);
        reg_read(5, 0, d, lat);
        n_cmp++; if (d !== 32'h10) begin n_fail++; $display("FAIL wrap_w0: got %h required 10", d); end
        reg_read(5, 1, d, lat);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL wrap_w1: got %h required 0", d); end
    endtask

    task automatic test_snapshot();
        logic [31:0] d;
        int          lat;
        @(negedge clk);
        dut.u_ram.mem[2] <= 64'h0000_0001_0000_0005;
        reg_read(2, 0, d, lat);
        n_cmp++; if (d !== 32'h5) begin n_fail++; $display("FAIL snap_w0: got %h required 5", d); end
        send_beat(2, 1);
        reg_read(2, 1, d, lat);
        n_cmp++; if (d !== 32'h1) begin n_fail++; $display("FAIL snap_w1: got %h required 1", d); end
        reg_read(2, 0, d, lat);
        n_cmp++; if (d !== 32'h6) begin n_fail++; $display("FAIL snap_reread_w0: got %h required 6", d); end
        // Word 1 of counter 7 is live 0, but comes from counter 2's snapshot
        reg_read(7, 1, d, lat);
        n_cmp++; if (d !== 32'h1) begin n_fail++; $display("FAIL snap_not_live: got %h required 1", d); end
    endtask

    task automatic test_back_to_back();
        int          beats;
        int          acks;
        int          reads;
        int          gap;
        int          max_gap;
        int          dbl;
        logic        prev_hs;
        logic [31:0] d;
        int          lat;
        beats = 0; acks = 0; reads = 0; gap = 0; max_gap = 0; dbl = 0; prev_hs = 1'b0;
        repeat (4) @(negedge clk);
        s_axis_stat_tvalid = 1'b1;
        s_axis_stat_tid    = 5'd1;
        s_axis_stat_tdata  = 16'd3;
        reg_rd_addr        = 8'(1 * 8);
        reg_rd_en          = 1'b1;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (s_axis_stat_tready) beats++;
            if (s_axis_stat_tready && prev_hs) dbl++;
            prev_hs = s_axis_stat_tready;
            if (!reg_rd_wait && !reg_rd_ack) reads++;
            if (reg_rd_ack) begin
                acks++;
                gap = 0;
            end else begin
                gap++;
                if (gap > max_gap) max_gap = gap;
            end
            @(negedge clk);
        end
        s_axis_stat_tvalid = 1'b0;
        reg_rd_en          = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (reg_rd_ack) acks++;
            @(negedge clk);
        end
        n_cmp++; if (acks !== reads) begin n_fail++; $display("FAIL b2b_reads: acks %0d required %0d", acks, reads); end
        n_cmp++; if (dbl !== 0) begin n_fail++; $display("FAIL b2b_tready_rate: %0d back-to-back accepts, required 0", dbl); end
        n_cmp++; if (beats < 5) begin n_fail++; $display("FAIL b2b_beats: got %0d required at least 5", beats); end
        n_cmp++; if (acks < 5) begin n_fail++; $display("FAIL b2b_acks: got %0d required at least 5", acks); end
        n_cmp++; if (max_gap > 8) begin n_fail++; $display("FAIL b2b_ack_gap: got %0d required at most 8", max_gap); end
        reg_read(1, 0, d, lat);
        n_cmp++; if (d !== 32'(beats * 3)) begin n_fail++; $display("FAIL b2b_total: got %h required %h", d, 32'(beats * 3)); end
    endtask

    task automatic test_reset_mid();
        int          seen;
        int          ack_cnt;
        logic [31:0] d;
        int          lat;
        int          ids[6] = '{1, 2, 3, 5, 6, 7};
        // Reset while the update is in its write cycle
        repeat (3) @(negedge clk);
        s_axis_stat_tvalid = 1'b1;
        s_axis_stat_tid    = 5'd6;
        s_axis_stat_tdata  = 16'd9;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (s_axis_stat_tready) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++; if (seen !== 1) begin n_fail++; $display("FAIL mid_upd_accept: got %0d required 1", seen); end
        @(negedge clk);
        s_axis_stat_tvalid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (s_axis_stat_tready !== 1'b0) begin n_fail++; $display("FAIL mid_upd_tready: got %b required 0", s_axis_stat_tready); end
        n_cmp++; if (reg_rd_data !== 32'h0) begin n_fail++; $display("FAIL mid_upd_data: got %h required 0", reg_rd_data); end
        n_cmp++; if (reg_rd_wait !== 1'b0) begin n_fail++; $display("FAIL mid_upd_wait: got %b required 0", reg_rd_wait); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (34) @(negedge clk);
        foreach (ids[k]) begin
            reg_read(ids[k], 0, d, lat);
            n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL cleared_cnt%0d: got %h required 0", ids[k], d); end
        end

        // Reset while a register read is in flight
        send_beat(3, 5);
        repeat (4) @(negedge clk);
        reg_rd_addr = 8'(3 * 8);
        reg_rd_en   = 1'b1;
        @(negedge clk);
        reg_rd_en = 1'b0;
        #1;
        n_cmp++; if (reg_rd_wait !== 1'b1) begin n_fail++; $display("FAIL mid_rd_wait: got %b required 1", reg_rd_wait); end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (reg_rd_wait !== 1'b0) begin n_fail++; $display("FAIL mid_rd_wait_rst: got %b required 0", reg_rd_wait); end
        ack_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            #1;
            if (reg_rd_ack) ack_cnt++;
        end
        n_cmp++; if (ack_cnt !== 0) begin n_fail++; $display("FAIL mid_rd_ack: got %0d acks required 0", ack_cnt); end
        reg_read(3, 0, d, lat);
        n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_rd_cleared: got %h required 0", d); end
    endtask

    initial begin
        rst_n              = 1'b0;
        s_axis_stat_tvalid = 1'b0;
        s_axis_stat_tid    = 5'd0;
        s_axis_stat_tdata  = 16'd0;
        reg_rd_en          = 1'b0;
        reg_rd_addr        = 8'd0;
        test_reset();
        test_basic();
        test_wrap();
        test_snapshot();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
